// File: rtl/program_fetcher.sv
// Instruction fetch stage with a one-entry line buffer in front of program memory.
// Hits deliver the instruction in one cycle. Misses issue a held read request until memory answers.
module program_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        FETCHING = 3'b001,
        FETCHED  = 3'b010
    } state_t;

    state_t                             state;
    logic                               buf_valid;
    logic [PROGRAM_MEM_ADDR_BITS-1:0]   buf_tag;
    logic [PROGRAM_MEM_DATA_BITS-1:0]   buf_data;
    logic                               buf_hit;

    // A flush arriving with the lookup makes the buffer count as empty.
    assign buf_hit       = buf_valid && !flush && (buf_tag == current_pc);
    assign fetcher_state = state;

    // Handshake: mem_read_valid rises with mem_read_address and both hold steady
    // until mem_read_ready is sampled high on a rising edge; that edge completes
    // the transfer and drops valid. Ready is ignored whenever no request is open.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            instruction      <= '0;
            buf_valid        <= 1'b0;
            buf_tag          <= '0;
            buf_data         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_state == CORE_FETCH) begin
                        if (buf_hit) begin
                            instruction <= buf_data;
                            state       <= FETCHED;
                        end else begin
                            mem_read_valid   <= 1'b1;
                            mem_read_address <= current_pc;
                            state            <= FETCHING;
                        end
                    end
                end
                FETCHING: begin
                    // Runs to completion regardless of core_state or flush.
                    if (mem_read_ready) begin
                        mem_read_valid <= 1'b0;
                        instruction    <= mem_read_data;
                        buf_data       <= mem_read_data;
                        buf_tag        <= mem_read_address;
                        buf_valid      <= 1'b1;
                        state          <= FETCHED;
                    end
                end
                FETCHED: begin
                    if (core_state == CORE_DECODE) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Placed after the case so a same-edge refill still ends invalid.
            if (flush) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_program_fetcher.sv
// Directed bench for program_fetcher: driver tasks push expected requests and
// instructions into queues, and a negedge monitor pops them as the DUT presents them.
module tb_program_fetcher;

    localparam logic [2:0] FETCH    = 3'b001;
    localparam logic [2:0] DECODE   = 3'b010;
    localparam logic [2:0] OTHER    = 3'b100;
    localparam logic [2:0] S_IDLE   = 3'b000;
    localparam logic [2:0] S_FETCHING = 3'b001;
    localparam logic [2:0] S_FETCHED  = 3'b010;

    logic        clk;
    logic        reset;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        flush;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;

    logic [7:0]  exp_addr_q[$];
    logic [15:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        prev_valid = 1'b0;
    logic [2:0]  prev_state = 3'b000;

    program_fetcher #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .PROGRAM_MEM_DATA_BITS(16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .flush            (flush),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: a rising request and each entry into FETCHED pop one expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (mem_read_valid && !prev_valid) begin
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_request", 32'(mem_read_address), 32'hFFFF_FFFF);
                end else begin
                    check("request_address", 32'(mem_read_address), 32'(exp_addr_q.pop_front()));
                end
            end
            if (fetcher_state == S_FETCHED && prev_state != S_FETCHED) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_fetched", 32'(instruction), 32'hFFFF_FFFF);
                end else begin
                    check("instruction", 32'(instruction), 32'(exp_q.pop_front()));
                end
            end
        end
        prev_valid = mem_read_valid;
        prev_state = fetcher_state;
    end

    // Driver tasks
    task automatic fetch_miss(input logic [7:0] pc, input logic [15:0] data, input int lat,
                              input bit flush_start, input bit flush_mid, input bit flush_ready);
        exp_addr_q.push_back(pc);
        exp_q.push_back(data);
        @(negedge clk);
        core_state = FETCH;
        current_pc = pc;
        flush      = flush_start;
        @(negedge clk);
        flush      = 1'b0;
        core_state = OTHER;
        current_pc = ~pc;
        check("miss_state", 32'(fetcher_state), 32'(S_FETCHING));
        for (int i = 0; i < lat; i++) begin
            check("hold_valid", 32'(mem_read_valid), 32'd1);
            check("hold_address", 32'(mem_read_address), 32'(pc));
            flush = flush_mid && (i == 0);
            @(negedge clk);
            flush = 1'b0;
        end
        check("valid_at_ready", 32'(mem_read_valid), 32'd1);
        mem_read_ready = 1'b1;
        mem_read_data  = data;
        flush          = flush_ready;
        @(negedge clk);
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        flush          = 1'b0;
        check("done_state", 32'(fetcher_state), 32'(S_FETCHED));
        check("done_valid", 32'(mem_read_valid), 32'd0);
    endtask

    task automatic fetch_hit(input logic [7:0] pc, input logic [15:0] data);
        exp_q.push_back(data);
        @(negedge clk);
        core_state = FETCH;
        current_pc = pc;
        @(negedge clk);
        check("hit_state", 32'(fetcher_state), 32'(S_FETCHED));
        check("hit_no_request", 32'(mem_read_valid), 32'd0);
    endtask

    task automatic decode();
        @(negedge clk);
        core_state = DECODE;
        @(negedge clk);
        check("decode_to_idle", 32'(fetcher_state), 32'(S_IDLE));
        core_state = 3'b000;
    endtask

    initial begin
        reset          = 1'b1;
        core_state     = 3'b000;
        current_pc     = 8'h00;
        flush          = 1'b0;
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        #2 reset = 1'b0;
        @(negedge clk);
        check("reset_state", 32'(fetcher_state), 32'(S_IDLE));
        check("reset_valid", 32'(mem_read_valid), 32'd0);
        check("reset_address", 32'(mem_read_address), 32'd0);
        check("reset_instruction", 32'(instruction), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Stray ready in IDLE must not move anything.
        @(negedge clk);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hBEEF;
        @(negedge clk);
        mem_read_ready = 1'b0;
        check("idle_ready_state", 32'(fetcher_state), 32'(S_IDLE));
        check("idle_ready_instr", 32'(instruction), 32'd0);

        fetch_miss(8'h05, 16'h3123, 3, 1'b0, 1'b0, 1'b0);
        decode();
        fetch_hit(8'h05, 16'h3123);
        decode();

        // Tag mismatch, with a flush while the request is outstanding.
        fetch_miss(8'h06, 16'h4456, 1, 1'b0, 1'b1, 1'b0);
        decode();
        fetch_hit(8'h06, 16'h4456);
        decode();

        // Flush on the same edge as the response: delivered, but buffer ends empty.
        fetch_miss(8'h10, 16'h9A07, 2, 1'b0, 1'b0, 1'b1);
        decode();
        fetch_miss(8'h10, 16'h1111, 1, 1'b0, 1'b0, 1'b0);
        decode();

        // Flush with the FETCH start forces a miss despite a matching tag.
        fetch_miss(8'h10, 16'h2222, 1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            core_state     = FETCH;
            mem_read_ready = 1'b1;
            mem_read_data  = 16'hFFFF;
            @(negedge clk);
            check("hold_state", 32'(fetcher_state), 32'(S_FETCHED));
            check("hold_instr", 32'(instruction), 32'h2222);
            check("hold_no_request", 32'(mem_read_valid), 32'd0);
        end
        mem_read_ready = 1'b0;
        decode();

        // Async reset while a request is open.
        fetch_miss(8'h05, 16'h5A5A, 0, 1'b0, 1'b0, 1'b0);
        decode();
        exp_addr_q.push_back(8'h20);
        @(negedge clk);
        core_state = FETCH;
        current_pc = 8'h20;
        @(negedge clk);
        core_state = 3'b000;
        check("pre_reset_state", 32'(fetcher_state), 32'(S_FETCHING));
        #2 reset = 1'b0;
        #1;
        check("async_state", 32'(fetcher_state), 32'(S_IDLE));
        check("async_valid", 32'(mem_read_valid), 32'd0);
        check("async_address", 32'(mem_read_address), 32'd0);
        check("async_instr", 32'(instruction), 32'd0);
        @(negedge clk);
        reset          = 1'b1;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hDEAD;
        @(negedge clk);
        mem_read_ready = 1'b0;
        check("late_ready_state", 32'(fetcher_state), 32'(S_IDLE));
        check("late_ready_instr", 32'(instruction), 32'd0);

        // Buffer held pc 0x05 before reset; the first fetch must still miss.
        fetch_miss(8'h05, 16'h6B6B, 1, 1'b0, 1'b0, 1'b0);
        decode();

        repeat (2) @(negedge clk);
        check("leftover_requests", 32'(exp_addr_q.size()), 32'd0);
        check("leftover_instructions", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_fetcher.md
PROGRAM_FETCHER -- requirements
Module: program_fetcher

Interface
REQ-001 SHALL provide parameter PROGRAM_MEM_ADDR_BITS, default 8: program memory address width.
REQ-002 SHALL provide parameter PROGRAM_MEM_DATA_BITS, default 16: instruction width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port core_state  input  3  core phase; FETCH=3'b001, DECODE=3'b010, all others ignored.
REQ-006 SHALL have port current_pc  input  PROGRAM_MEM_ADDR_BITS  address of instruction to fetch.
REQ-007 SHALL have port flush  input  1  invalidate line buffer (after program load or PC redirect).
REQ-008 SHALL have port mem_read_valid  output  1  read request to program memory.
REQ-009 SHALL have port mem_read_address  output  PROGRAM_MEM_ADDR_BITS  request address.
REQ-010 SHALL have port mem_read_ready  input  1  memory response valid; data on mem_read_data.
REQ-011 SHALL have port mem_read_data  input  PROGRAM_MEM_DATA_BITS  returned instruction.
REQ-012 SHALL have port fetcher_state  output  3  IDLE=3'b000, FETCHING=3'b001, FETCHED=3'b010.
REQ-013 SHALL have port instruction  output  PROGRAM_MEM_DATA_BITS  fetched instruction to the decode stage.

Function
REQ-014 SHALL hold a one-entry line buffer: buf_valid, buf_tag (address), buf_data (instruction).
REQ-015 In IDLE with core_state==FETCH and buf_valid and buf_tag==current_pc (hit), SHALL load instruction<=buf_data and go to FETCHED next edge, no memory request; hit latency 1 cycle.
REQ-016 In IDLE with core_state==FETCH on miss, SHALL set mem_read_valid<=1, mem_read_address<=current_pc, go to FETCHING.
REQ-017 In FETCHING, mem_read_valid and mem_read_address SHALL stay constant until mem_read_ready sampled high.
REQ-018 In FETCHING with mem_read_ready=1, SHALL on the same edge: mem_read_valid<=0, instruction<=mem_read_data, buf_data<=mem_read_data, buf_tag<=mem_read_address, buf_valid<=1, go to FETCHED.
REQ-019 mem_read_ready while not FETCHING SHALL be ignored.
REQ-020 In FETCHED, SHALL go to IDLE when core_state==DECODE; otherwise remain FETCHED.
REQ-021 instruction SHALL change only on transition into FETCHED and stay stable through DECODE and all later phases.
REQ-022 flush=1 SHALL clear buf_valid next edge in any state; flush and mem_read_ready same edge: instruction delivered, buf_valid ends 0 (flush wins).
REQ-023 flush=1 in IDLE same edge as FETCH start SHALL force miss path (lookup treats buffer as invalid).
REQ-024 flush SHALL NOT abort an outstanding request.
REQ-025 core_state leaving FETCH while FETCHING SHALL NOT cancel the request; fetch completes normally.
REQ-026 fetcher_state SHALL equal the internal state register.
REQ-027 mem_read_valid SHALL be a register output, glitch-free.

Reset
REQ-028 reset=0 SHALL immediately, independent of clk, set fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, buf_valid=0, buf_tag=0, buf_data=0.
REQ-029 reset asserted mid-FETCHING SHALL drop the request; response arriving after reset release SHALL be ignored (state IDLE).
REQ-030 After reset release, first FETCH SHALL always miss.

Verification
REQ-031 Miss: reset, core_state=FETCH, current_pc=0x05, ready after 3 cycles with data 0x3123 -> valid high exactly until ready edge, address 0x05, FETCHED next edge, instruction=0x3123.
REQ-032 Hit: repeat FETCH at pc 0x05 after DECODE -> no mem_read_valid pulse, FETCHED 1 cycle after FETCH, instruction=0x3123.
REQ-033 Tag mismatch: FETCH pc 0x06 after buffer holds 0x05 -> request issued, address 0x06, buffer retagged 0x06.
REQ-034 Flush collision: flush and ready same edge (data 0x9A07) -> instruction=0x9A07, next FETCH same pc misses.
REQ-035 Async reset mid-fetch: drop reset in FETCHING between edges -> mem_read_valid=0, fetcher_state=IDLE without clock; late ready ignored.
REQ-036 Hold: stay FETCHED with core_state=FETCH 5 cycles -> instruction stable, no new request, IDLE one edge after DECODE.
